// File: rtl/io_timer_pkg.sv
// Shared I/O definitions for the memory-mapped timer:
// register offsets, control/status bit positions and reset constants.
package io_timer_pkg;

   localparam logic [15:0] IO_TIMER_BASE = 16'h1010;

   typedef enum logic [2:0] {
      OFF_CTRL     = 3'd0,
      OFF_PRESCALE = 3'd1,
      OFF_COUNT_L  = 3'd2,
      OFF_COUNT_H  = 3'd3,
      OFF_CMP_L    = 3'd4,
      OFF_CMP_H    = 3'd5,
      OFF_STATUS   = 3'd6
   } io_reg_e;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_IE    = 1;
   localparam int CTRL_AUTO  = 2;
   localparam int STAT_MATCH = 0;

   localparam logic [15:0] CMP_RST = 16'hFFFF;

endpackage

// File: rtl/io_timer_prescaler.sv
// Clock divider for the timer: one-cycle tick every reload+1
// enabled cycles, restarted whenever cleared or disabled.
module io_prescaler (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] reload,
   input  logic       clr,
   output logic       tick
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick = en && (cnt_q == reload);

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (!en || clr || tick) begin
         cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit compare timer with prescaler, shadowed
// count read-back and a level interrupt.
module io_timer
   import io_timer_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = IO_TIMER_BASE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] dMemIOAddress,
   input  logic [7:0]  dMemIOIn,
   input  logic        dMemIOWriteEn,
   input  logic        dMemIOReadEn,
   output logic [15:0] dMemIOOut,
   output logic        interrupt_0,
   input  logic        interrupt_0_clr
);

   logic [2:0]  ctrl_q, ctrl_d;
   logic [7:0]  prescale_q, prescale_d;
   logic [15:0] count_q, count_d;
   logic [15:0] cmp_q, cmp_d;
   logic        match_q, match_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [7:0]  rdata_q, rdata_d;

   logic [15:0] off_full;
   logic        hit;
   io_reg_e     sel;
   logic        wr_ctrl, wr_pre, wr_cl, wr_ch;
   logic        wr_ml, wr_mh, wr_st;
   logic        tick;
   logic        match_set;

   // Wrapping subtraction makes addresses below the base fail the range test.
   assign off_full = dMemIOAddress - BASE_ADDR;
   assign hit      = off_full < 16'd7;
   assign sel      = io_reg_e'(off_full[2:0]);

   assign dMemIOOut   = {8'h00, rdata_q};
   assign interrupt_0 = match_q & ctrl_q[CTRL_IE];

   io_prescaler u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ctrl_q[CTRL_EN]),
      .reload (prescale_q),
      .clr    (wr_pre),
      .tick   (tick)
   );

   always_comb begin
      wr_ctrl = 1'b0;
      wr_pre  = 1'b0;
      wr_cl   = 1'b0;
      wr_ch   = 1'b0;
      wr_ml   = 1'b0;
      wr_mh   = 1'b0;
      wr_st   = 1'b0;
      if (dMemIOWriteEn && hit) begin
         case (sel)
            OFF_CTRL:     wr_ctrl = 1'b1;
            OFF_PRESCALE: wr_pre  = 1'b1;
            OFF_COUNT_L:  wr_cl   = 1'b1;
            OFF_COUNT_H:  wr_ch   = 1'b1;
            OFF_CMP_L:    wr_ml   = 1'b1;
            OFF_CMP_H:    wr_mh   = 1'b1;
            OFF_STATUS:   wr_st   = 1'b1;
            default:      ;
         endcase
      end
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      cmp_d      = cmp_q;
      match_d    = match_q;
      match_set  = 1'b0;

      if (tick) begin
         if (count_q == cmp_q) begin
            match_set = 1'b1;
            if (ctrl_q[CTRL_AUTO]) begin
               count_d = 16'h0000;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
            end
         end else begin
            count_d = count_q + 16'd1;
         end
      end

      // Bus writes land after the tick update so they take priority per byte.
      if (wr_ctrl) ctrl_d = dMemIOIn[2:0];
      if (wr_pre)  prescale_d = dMemIOIn;
      if (wr_cl)   count_d[7:0] = dMemIOIn;
      if (wr_ch)   count_d[15:8] = dMemIOIn;
      if (wr_ml)   cmp_d[7:0] = dMemIOIn;
      if (wr_mh)   cmp_d[15:8] = dMemIOIn;

      if (interrupt_0_clr || (wr_st && dMemIOIn[STAT_MATCH])) begin
         match_d = 1'b0;
      end
      if (match_set) begin
         match_d = 1'b1;
      end
   end

   always_comb begin
      rdata_d  = 8'h00;
      shadow_d = shadow_q;
      if (dMemIOReadEn && hit) begin
         case (sel)
            OFF_CTRL:     rdata_d = {5'b00000, ctrl_q};
            OFF_PRESCALE: rdata_d = prescale_q;
            OFF_COUNT_L: begin
               rdata_d  = count_q[7:0];
               shadow_d = count_q[15:8];
            end
            OFF_COUNT_H:  rdata_d = shadow_q;
            OFF_CMP_L:    rdata_d = cmp_q[7:0];
            OFF_CMP_H:    rdata_d = cmp_q[15:8];
            OFF_STATUS:   rdata_d = {7'b0000000, match_q};
            default:      rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= 3'b000;
         prescale_q <= 8'h00;
         count_q    <= 16'h0000;
         cmp_q      <= CMP_RST;
         match_q    <= 1'b0;
         shadow_q   <= 8'h00;
         rdata_q    <= 8'h00;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         cmp_q      <= cmp_d;
         match_q    <= match_d;
         shadow_q   <= shadow_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: read expectations are queued at issue
// time and a negedge monitor checks them when the data is due.
module tb_io_timer;

   localparam logic [15:0] B = 16'h1010;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  din;
   logic        we;
   logic        re;
   logic [15:0] dout;
   logic        intr;
   logic        iclr;

   int total = 0;
   int bad   = 0;

   string       nm_q[$];
   logic [15:0] ex_q[$];
   logic        rd_d;

   io_timer #(.BASE_ADDR(B)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dMemIOAddress   (addr),
      .dMemIOIn        (din),
      .dMemIOWriteEn   (we),
      .dMemIOReadEn    (re),
      .dMemIOOut       (dout),
      .interrupt_0     (intr),
      .interrupt_0_clr (iclr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_irq(input logic e, input string nm);
      check(nm, {15'd0, intr}, {15'd0, e});
   endtask

   // Tasks are entered at a negedge and return at the next negedge.
   task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
      addr = B + {13'd0, off};
      din  = d;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
      addr = 16'h0000;
   endtask

   task automatic bus_rd(input logic [15:0] a, input logic [7:0] e,
                         input string nm);
      addr = a;
      re   = 1'b1;
      nm_q.push_back(nm);
      ex_q.push_back({8'h00, e});
      @(negedge clk);
      re   = 1'b0;
      addr = 16'h0000;
   endtask

   task automatic rd(input logic [2:0] off, input logic [7:0] e,
                     input string nm);
      bus_rd(B + {13'd0, off}, e, nm);
   endtask

   task automatic bus_rw(input logic [2:0] off, input logic [7:0] d,
                         input logic [7:0] e, input string nm);
      addr = B + {13'd0, off};
      din  = d;
      we   = 1'b1;
      re   = 1'b1;
      nm_q.push_back(nm);
      ex_q.push_back({8'h00, e});
      @(negedge clk);
      we   = 1'b0;
      re   = 1'b0;
      addr = 16'h0000;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_d <= 1'b0;
      else        rd_d <= re;
   end

   always @(negedge clk) begin
      if (rd_d) begin
         if (ex_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read: got %h want none", dout);
         end else begin
            check(nm_q.pop_front(), dout, ex_q.pop_front());
         end
      end else begin
         check("idle_bus", dout, 16'h0000);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      addr  = 16'h0000;
      din   = 8'h00;
      we    = 1'b0;
      re    = 1'b0;
      iclr  = 1'b0;
      #3;
      check("rst_out", dout, 16'h0000);
      chk_irq(1'b0, "rst_irq");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      rd(3'd0, 8'h00, "rst_ctrl");
      rd(3'd1, 8'h00, "rst_pre");
      rd(3'd2, 8'h00, "rst_cnt_l");
      rd(3'd4, 8'hFF, "rst_cmp_l");
      rd(3'd5, 8'hFF, "rst_cmp_h");
      rd(3'd6, 8'h00, "rst_stat");

      // auto-reload match after the fourth tick
      bus_wr(3'd4, 8'h03);
      bus_wr(3'd5, 8'h00);
      bus_wr(3'd0, 8'h07);
      chk_irq(1'b0, "t1_irq_early");
      repeat (3) @(negedge clk);
      chk_irq(1'b0, "t1_irq_tick3");
      @(negedge clk);
      chk_irq(1'b1, "t1_irq_tick4");
      rd(3'd2, 8'h00, "t1_cnt_zero");
      bus_wr(3'd0, 8'h00);
      rd(3'd6, 8'h01, "t1_match");
      bus_wr(3'd6, 8'h01);
      rd(3'd6, 8'h00, "t1_stat_clr");

      // one-shot with prescale 4
      bus_wr(3'd2, 8'h00);
      bus_wr(3'd3, 8'h00);
      bus_wr(3'd1, 8'h04);
      bus_wr(3'd4, 8'h02);
      bus_wr(3'd0, 8'h01);
      repeat (5) @(negedge clk);
      rd(3'd2, 8'h01, "t2_tick1");
      repeat (4) @(negedge clk);
      rd(3'd2, 8'h02, "t2_tick2");
      repeat (4) @(negedge clk);
      rd(3'd6, 8'h01, "t2_match");
      rd(3'd0, 8'h00, "t2_en_clr");
      rd(3'd2, 8'h02, "t2_hold");
      chk_irq(1'b0, "t2_irq_ie0");
      repeat (10) @(negedge clk);
      rd(3'd2, 8'h02, "t2_hold_late");
      bus_wr(3'd6, 8'h01);

      // wrap FFFF -> 0000 -> 0001 then match
      bus_wr(3'd1, 8'h00);
      bus_wr(3'd2, 8'hFF);
      bus_wr(3'd3, 8'hFF);
      bus_wr(3'd4, 8'h01);
      bus_wr(3'd5, 8'h00);
      bus_wr(3'd0, 8'h03);
      @(negedge clk);
      rd(3'd2, 8'h00, "t3_wrap");
      rd(3'd2, 8'h01, "t3_after_wrap");
      chk_irq(1'b1, "t3_irq");
      rd(3'd6, 8'h01, "t3_match");
      rd(3'd0, 8'h02, "t3_en_clr");

      // interrupt acknowledge, alone and against a new match
      iclr = 1'b1;
      @(negedge clk);
      iclr = 1'b0;
      chk_irq(1'b0, "t4_clr");
      rd(3'd6, 8'h00, "t4_stat");
      bus_wr(3'd0, 8'h07);
      repeat (2) @(negedge clk);
      iclr = 1'b1;
      @(negedge clk);
      iclr = 1'b0;
      chk_irq(1'b1, "t4_set_wins");
      iclr = 1'b1;
      @(negedge clk);
      iclr = 1'b0;
      chk_irq(1'b0, "t4_clr2");
      bus_wr(3'd0, 8'h00);
      bus_wr(3'd6, 8'h01);
      rd(3'd6, 8'h00, "t4_stat2");

      // shadowed high byte
      bus_wr(3'd2, 8'hFF);
      bus_wr(3'd3, 8'h12);
      bus_wr(3'd4, 8'hFF);
      bus_wr(3'd5, 8'hFF);
      rd(3'd2, 8'hFF, "t5_cnt_l");
      bus_wr(3'd0, 8'h01);
      bus_wr(3'd0, 8'h00);
      rd(3'd3, 8'h12, "t5_shadow");
      rd(3'd2, 8'h00, "t5_cnt_l2");
      rd(3'd3, 8'h13, "t5_cnt_h2");
      bus_rd(B + 16'd7, 8'h00, "t5_miss_hi");
      bus_rd(B - 16'd1, 8'h00, "t5_miss_lo");
      rd(3'd5, 8'hFF, "t5_cmp_h");

      // same-cycle collisions
      bus_rw(3'd1, 8'h05, 8'h00, "t6_rw_old");
      rd(3'd1, 8'h05, "t6_rw_new");
      bus_wr(3'd1, 8'h00);
      bus_wr(3'd2, 8'hFF);
      bus_wr(3'd3, 8'h00);
      bus_wr(3'd0, 8'h01);
      bus_wr(3'd3, 8'h55);
      bus_wr(3'd0, 8'h00);
      rd(3'd2, 8'h01, "t6_coinc_l");
      rd(3'd3, 8'h55, "t6_coinc_h");
      bus_wr(3'd2, 8'h05);
      bus_wr(3'd3, 8'h00);
      bus_wr(3'd4, 8'h05);
      bus_wr(3'd5, 8'h00);
      bus_wr(3'd0, 8'h01);
      bus_wr(3'd0, 8'h05);
      rd(3'd0, 8'h05, "t6_ctrl_wins");
      bus_wr(3'd0, 8'h00);
      bus_wr(3'd6, 8'h01);

      // asynchronous reset mid-count
      bus_wr(3'd2, 8'h00);
      bus_wr(3'd4, 8'h02);
      bus_wr(3'd0, 8'h07);
      repeat (4) @(negedge clk);
      chk_irq(1'b1, "t7_irq_pre");
      addr = B;
      re   = 1'b1;
      @(posedge clk);
      #2;
      check("t7_rd_pre", dout, 16'h0007);
      rst_n = 1'b0;
      #1;
      check("t7_rst_out", dout, 16'h0000);
      chk_irq(1'b0, "t7_rst_irq");
      re   = 1'b0;
      addr = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(3'd0, 8'h00, "t7_ctrl");
      rd(3'd1, 8'h00, "t7_pre");
      rd(3'd3, 8'h00, "t7_shadow");
      rd(3'd2, 8'h00, "t7_cnt_l");
      rd(3'd4, 8'hFF, "t7_cmp_l");
      rd(3'd5, 8'hFF, "t7_cmp_h");
      rd(3'd6, 8'h00, "t7_stat");
      repeat (10) @(negedge clk);
      rd(3'd2, 8'h00, "t7_idle");
      chk_irq(1'b0, "t7_irq_idle");
      repeat (2) @(negedge clk);

      if (ex_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d pending want 0", ex_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
